// File: rtl/ctrl_seq_monitor_if.sv
// Output bus of the multicycle MIPS control unit.
// master = control unit, slave = passive consumers such as the monitor.
interface ctrl_seq_monitor_if;
   logic       IorD;
   logic       MemRead;
   logic       MemWrite;
   logic       MemToReg;
   logic       IRWrite;
   logic       RegDst;
   logic       RegWrite;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ALUOp;
   logic [1:0] PCSource;
   logic       PCWrite;
   logic       PCWriteCond;

   modport master (
      output IorD, MemRead, MemWrite, MemToReg, IRWrite, RegDst,
      output RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
      output PCWrite, PCWriteCond
   );

   modport slave (
      input IorD, MemRead, MemWrite, MemToReg, IRWrite, RegDst,
      input RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
      input PCWrite, PCWriteCond
   );
endinterface

// File: rtl/ctrl_seq_monitor.sv
// Passive checker for the multicycle MIPS control-unit output sequence.
// Define CTRL_SEQ_OPCODE_CHECK_EN to add Opcode/Funct cross-checking.
module ctrl_seq_monitor #(
   parameter int CNT_W = 16
) (
   input  logic             Clk,
   input  logic             reset,
   ctrl_seq_monitor_if.slave ctrlBus,
`ifdef CTRL_SEQ_OPCODE_CHECK_EN
   input  logic [5:0]       Opcode,
   input  logic [5:0]       Funct,
`endif
   output logic             instr_done,
   output logic [2:0]       instr_class,
   output logic [3:0]       instr_cycles,
   output logic [CNT_W-1:0] instr_count,
   output logic             err,
   output logic [2:0]       err_code
);

   typedef enum logic [3:0] {
      V_UNK, V_FETCH, V_DECODE, V_ADDR, V_MRD, V_MWR,
      V_LWB, V_EXR, V_RWB, V_IWB, V_JMP, V_BEQ
   } vec_e;

   typedef enum logic [2:0] {
      S_IDLE, S_F, S_D, S_A, S_M, S_X
   } state_e;

   localparam logic [2:0] C_NONE = 3'd0;
   localparam logic [2:0] C_LW   = 3'd1;
   localparam logic [2:0] C_SW   = 3'd2;
   localparam logic [2:0] C_R    = 3'd3;
   localparam logic [2:0] C_ADDI = 3'd4;
   localparam logic [2:0] C_J    = 3'd5;
   localparam logic [2:0] C_BEQ  = 3'd6;

   localparam logic [2:0] E_NONE = 3'd0;
   localparam logic [2:0] E_UNK  = 3'd1;
   localparam logic [2:0] E_SEQ  = 3'd2;
   localparam logic [2:0] E_OP   = 3'd3;

   vec_e       vec;
   state_e     state;
   state_e     nxtState;
   state_e     advState;
   logic       resync;
   logic       nxtResync;
   logic       hit;
   logic       finish;
   logic       opErr;
   logic [2:0] doneCls;
   logic       doneEvt;
   logic       errEvt;
   logic [2:0] errCodeEvt;
   logic [3:0] cycCnt;
   logic [5:0] wr;
   logic [4:0] alu;

   // Write enables must match exactly; selects only where they matter
   assign wr = {ctrlBus.MemRead, ctrlBus.MemWrite, ctrlBus.IRWrite,
                ctrlBus.RegWrite, ctrlBus.PCWrite, ctrlBus.PCWriteCond};
   assign alu = {ctrlBus.ALUSrcA, ctrlBus.ALUSrcB, ctrlBus.ALUOp};

   always_comb begin
      vec = V_UNK;
      unique case (1'b1)
         wr == 6'b101010 && !ctrlBus.IorD && alu == 5'b0_01_00
            && ctrlBus.PCSource == 2'b00:               vec = V_FETCH;
         wr == 6'b000000 && alu == 5'b0_11_00:          vec = V_DECODE;
         wr == 6'b000000 && alu == 5'b1_10_00:          vec = V_ADDR;
         wr == 6'b100000 && ctrlBus.IorD:               vec = V_MRD;
         wr == 6'b010000 && ctrlBus.IorD:               vec = V_MWR;
         wr == 6'b000100 && !ctrlBus.RegDst
            && ctrlBus.MemToReg:                        vec = V_LWB;
         wr == 6'b000000 && alu == 5'b1_00_10:          vec = V_EXR;
         wr == 6'b000100 && ctrlBus.RegDst
            && !ctrlBus.MemToReg:                       vec = V_RWB;
         wr == 6'b000100 && !ctrlBus.RegDst
            && !ctrlBus.MemToReg:                       vec = V_IWB;
         wr == 6'b000010 && ctrlBus.PCSource == 2'b10:  vec = V_JMP;
         wr == 6'b000001 && alu == 5'b1_00_01
            && ctrlBus.PCSource == 2'b01:               vec = V_BEQ;
         default:                                       vec = V_UNK;
      endcase
   end

   // Legal-successor table
   always_comb begin
      hit      = 1'b0;
      finish   = 1'b0;
      advState = S_IDLE;
      doneCls  = C_NONE;
      unique case (state)
         S_IDLE: if (vec == V_FETCH) begin
            hit      = 1'b1;
            advState = S_F;
         end
         S_F: if (vec == V_DECODE) begin
            hit      = 1'b1;
            advState = S_D;
         end
         S_D: begin
            case (vec)
               V_ADDR: begin hit = 1'b1; advState = S_A; end
               V_EXR:  begin hit = 1'b1; advState = S_X; end
               V_JMP:  begin hit = 1'b1; finish = 1'b1; doneCls = C_J;   end
               V_BEQ:  begin hit = 1'b1; finish = 1'b1; doneCls = C_BEQ; end
               default: ;
            endcase
         end
         S_A: begin
            case (vec)
               V_MRD: begin hit = 1'b1; advState = S_M; end
               V_MWR: begin hit = 1'b1; finish = 1'b1; doneCls = C_SW;   end
               V_IWB: begin hit = 1'b1; finish = 1'b1; doneCls = C_ADDI; end
               default: ;
            endcase
         end
         S_M: if (vec == V_LWB) begin
            hit     = 1'b1;
            finish  = 1'b1;
            doneCls = C_LW;
         end
         S_X: if (vec == V_RWB) begin
            hit     = 1'b1;
            finish  = 1'b1;
            doneCls = C_R;
         end
         default: ;
      endcase
   end

`ifdef CTRL_SEQ_OPCODE_CHECK_EN
   logic [2:0] liveCls;
   logic [2:0] implCls;

   function automatic logic [2:0] opClass(input logic [5:0] op,
                                          input logic [5:0] fn);
      case (op)
         6'h23:   opClass = C_LW;
         6'h2B:   opClass = C_SW;
         6'h00:   opClass = (fn == 6'h20 || fn == 6'h22) ? C_R : C_NONE;
         6'h08:   opClass = C_ADDI;
         6'h02:   opClass = C_J;
         6'h04:   opClass = C_BEQ;
         default: opClass = C_NONE;
      endcase
   endfunction

   assign liveCls = opClass(Opcode, Funct);

   always_comb begin
      opErr = 1'b0;
      if (hit && state == S_D) begin
         case (vec)
            V_ADDR:  opErr = !(liveCls inside {C_LW, C_SW, C_ADDI});
            V_EXR:   opErr = liveCls != C_R;
            V_JMP:   opErr = liveCls != C_J;
            V_BEQ:   opErr = liveCls != C_BEQ;
            default: opErr = 1'b0;
         endcase
      end else if (hit && finish) begin
         opErr = implCls != doneCls;
      end
   end

   always_ff @(posedge Clk or negedge reset) begin
      if (!reset)
         implCls <= C_NONE;
      else if (state == S_D)
         implCls <= liveCls;
   end
`else
   assign opErr = 1'b0;
`endif

   always_ff @(posedge Clk or negedge reset) begin
      if (!reset) begin
         state  <= S_IDLE;
         resync <= 1'b0;
      end else begin
         state  <= nxtState;
         resync <= nxtResync;
      end
   end

   // A FETCH always starts a new instruction, even mid-sequence
   always_comb begin
      nxtState  = state;
      nxtResync = resync;
      if (vec == V_FETCH) begin
         nxtState  = S_F;
         nxtResync = 1'b0;
      end else if (hit && !opErr) begin
         nxtState = finish ? S_IDLE : advState;
      end else if (!(state == S_IDLE && resync)) begin
         nxtState  = S_IDLE;
         nxtResync = 1'b1;
      end
   end

   always_comb begin
      doneEvt    = hit && finish && !opErr;
      errEvt     = 1'b0;
      errCodeEvt = E_NONE;
      if (vec == V_FETCH) begin
         if (state != S_IDLE) begin
            errEvt     = 1'b1;
            errCodeEvt = E_SEQ;
         end
      end else if (!(hit && !opErr) && !(state == S_IDLE && resync)) begin
         errEvt = 1'b1;
         if (opErr)
            errCodeEvt = E_OP;
         else if (vec == V_UNK)
            errCodeEvt = E_UNK;
         else
            errCodeEvt = E_SEQ;
      end
   end

   always_ff @(posedge Clk or negedge reset) begin
      if (!reset) begin
         cycCnt       <= 4'd0;
         instr_done   <= 1'b0;
         instr_class  <= C_NONE;
         instr_cycles <= 4'd0;
         instr_count  <= '0;
         err          <= 1'b0;
         err_code     <= E_NONE;
      end else begin
         if (vec == V_FETCH)
            cycCnt <= 4'd1;
         else if (hit && !finish && !opErr)
            cycCnt <= cycCnt + 4'd1;
         instr_done <= doneEvt;
         if (doneEvt) begin
            instr_class  <= doneCls;
            instr_cycles <= cycCnt + 4'd1;
            if (instr_count != {CNT_W{1'b1}})
               instr_count <= instr_count + CNT_W'(1);
         end
         if (errEvt) begin
            err <= 1'b1;
            if (!err)
               err_code <= errCodeEvt;
         end
      end
   end

endmodule
